// File: rtl/usb_link_tx.sv
// Device-side USB link transmitter: serialises handshake and data packets
// (PID, payload, CRC16) into a byte-wide FIFO stream with sop/eop framing.
module usb_link_tx #(
    parameter logic [15:0] CRC16_INIT  = 16'hFFFF,
    parameter int unsigned MAX_PAYLOAD = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_pid_en,
    input  logic [3:0] tx_pid,
    input  logic       tx_zlp,
    input  logic       tx_lt_valid,
    input  logic [7:0] tx_lt_data,
    input  logic       tx_lt_eop,
    output logic       tx_lt_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_sop,
    output logic       tx_eop,
    input  logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_pid_err
);

    localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PID    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;

    // Reflected CRC16 (poly 0x8005 -> 0xA001), data consumed LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [15:0]   crc_q, crc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hs_q, hs_d, zlp_q, zlp_d;
    logic          valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d, err_q, err_d;
    logic          out_free, lt_ready, pid_hs, pid_data;

    assign out_free = ~valid_q | tx_ready;
    assign lt_ready = (state_q == S_DATA) & out_free;
    assign pid_hs   = (tx_pid == 4'b0010) | (tx_pid == 4'b1010) | (tx_pid == 4'b1110);
    assign pid_data = (tx_pid == 4'b0011) | (tx_pid == 4'b1011);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        hs_d    = hs_q;
        zlp_d   = zlp_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (valid_q & tx_ready) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_pid_en) begin
                    if (pid_hs | pid_data) begin
                        valid_d = 1'b1;
                        data_d  = {~tx_pid, tx_pid};
                        sop_d   = 1'b1;
                        eop_d   = pid_hs;
                        hs_d    = pid_hs;
                        zlp_d   = tx_zlp;
                        crc_d   = CRC16_INIT;
                        cnt_d   = '0;
                        state_d = S_PID;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PID: begin
                if (valid_q & tx_ready) begin
                    if (hs_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (zlp_q) begin
                        state_d = S_CRC_LO;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tx_lt_valid & lt_ready) begin
                    valid_d = 1'b1;
                    data_d  = tx_lt_data;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    crc_d   = crc16_byte(crc_q, tx_lt_data);
                    cnt_d   = cnt_q + CW'(1);
                    if (tx_lt_eop || (cnt_q == CW'(MAX_PAYLOAD - 1))) state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = ~crc_q[7:0];
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    state_d = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                // Register holds CRC_LO until it drains, then CRC_HI; leave once the eop byte goes.
                if (valid_q & eop_q & tx_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = ~crc_q[15:8];
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            crc_q   <= CRC16_INIT;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            zlp_q   <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            hs_q    <= hs_d;
            zlp_q   <= zlp_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tx_lt_ready = lt_ready;
    assign tx_valid    = valid_q;
    assign tx_data     = data_q;
    assign tx_sop      = sop_q;
    assign tx_eop      = eop_q;
    assign tx_busy     = (state_q != S_IDLE);
    assign tx_done     = done_q;
    assign tx_pid_err  = err_q;

endmodule

// File: tb/tb_usb_link_tx.sv
// Scoreboard bench for usb_link_tx: expected bytes are queued per request and
// popped on each FIFO-side transfer; CRC bytes come from a non-reflected model.
module tb_usb_link_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_pid_en, tx_zlp, tx_lt_valid, tx_lt_eop, tx_ready;
    logic [3:0] tx_pid;
    logic [7:0] tx_lt_data;
    logic       tx_lt_ready, tx_valid, tx_sop, tx_eop, tx_busy, tx_done, tx_pid_err;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    usb_link_tx #(.CRC16_INIT(16'hFFFF), .MAX_PAYLOAD(8)) dut (
        .clk(clk), .rst(rst),
        .tx_pid_en(tx_pid_en), .tx_pid(tx_pid), .tx_zlp(tx_zlp),
        .tx_lt_valid(tx_lt_valid), .tx_lt_data(tx_lt_data), .tx_lt_eop(tx_lt_eop),
        .tx_lt_ready(tx_lt_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_pid_err(tx_pid_err)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Non-reflected form: shift left with 0x8005, byte bits taken LSB-first.
    function automatic logic [15:0] crc_ref(input logic [15:0] r, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] o;
        for (int i = 0; i < 16; i++) o[i] = v[15-i];
        return o;
    endfunction

    logic [9:0]  sbq[$];
    bit          sb_en = 1'b1;
    bit          ready_toggle = 1'b0;
    int          done_cnt = 0, err_cnt = 0, busy_cyc = 0;
    logic        prev_eop_xfer = 1'b0, prev_stall = 1'b0, rdata = 1'b0;
    logic [9:0]  prev_word = '0;
    logic [9:0]  exp_w;
    logic [15:0] rreg = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_eop_xfer = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (tx_busy)    busy_cyc++;
            if (tx_pid_err) err_cnt++;
            if (tx_done)    done_cnt++;
            if (sb_en && (tx_done || prev_eop_xfer)) chk("done_pulse", 32'(tx_done), 32'(prev_eop_xfer));
            if (sb_en && prev_stall) chk("hold_stable", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, prev_word});
            if (sb_en && tx_valid && tx_ready) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_w = sbq.pop_front();
                    chk("byte", {tx_sop, tx_eop, tx_data}, exp_w);
                end
                if (tx_sop) begin
                    rdata = (tx_data == 8'hC3) || (tx_data == 8'h4B);
                    rreg  = 16'hFFFF;
                end else if (rdata) begin
                    rreg = crc_ref(rreg, tx_data);
                    if (tx_eop) chk("crc_residual", rreg, 16'h800D);
                end
            end
            prev_eop_xfer = tx_valid & tx_ready & tx_eop;
            prev_stall    = tx_valid & ~tx_ready;
            prev_word     = {tx_sop, tx_eop, tx_data};
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_toggle ? ~tx_ready : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [3:0] pid, input logic [7:0] pl[$]);
        logic        hs;
        logic [15:0] r;
        hs = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
        sbq.push_back({1'b1, hs, ~pid, pid});
        if (!hs) begin
            r = 16'hFFFF;
            foreach (pl[i]) begin
                sbq.push_back({2'b00, pl[i]});
                r = crc_ref(r, pl[i]);
            end
            r = bitrev16(r);
            sbq.push_back({2'b00, ~r[7:0]});
            sbq.push_back({2'b01, ~r[15:8]});
        end
    endtask

    task automatic req(input logic [3:0] pid, input logic zlp);
        tx_pid    = pid;
        tx_zlp    = zlp;
        tx_pid_en = 1'b1;
        tick();
        tx_pid_en = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] pl[$], input bit last_eop, input bit gaps, input bit poke);
        int t;
        foreach (pl[i]) begin
            if (gaps && (i % 2 == 1)) begin
                tx_lt_valid = 1'b0;
                if (poke && i == 1) begin
                    tx_pid    = 4'b1001;
                    tx_pid_en = 1'b1;
                end
                tick();
                tx_pid_en = 1'b0;
            end
            tx_lt_valid = 1'b1;
            tx_lt_data  = pl[i];
            tx_lt_eop   = last_eop && (i == pl.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (tx_lt_ready || t > 100) break;
                t++;
            end
            if (t > 100) chk("lt_ready_seen", 32'(tx_lt_ready), 32'd1);
            tick();
        end
        tx_lt_valid = 1'b0;
        tx_lt_eop   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain", 32'(sbq.size()), 32'd0);
        tick();
        tick();
    endtask

    logic [7:0] p_none[$];
    logic [7:0] p4[$]   = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0] p8[$]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] p2[$]   = '{8'hAA, 8'h55};
    int d0, b0, e0;

    initial begin
        rst = 1'b1;
        tx_pid_en = 1'b0; tx_pid = '0; tx_zlp = 1'b0;
        tx_lt_valid = 1'b0; tx_lt_data = '0; tx_lt_eop = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {tx_valid, tx_sop, tx_eop, tx_data, tx_busy, tx_done, tx_pid_err, tx_lt_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // ACK handshake
        d0 = done_cnt; b0 = busy_cyc;
        push_pkt(4'b0010, p_none);
        req(4'b0010, 1'b0);
        @(negedge clk);
        chk("ack_latency", {tx_valid, tx_sop, tx_eop, tx_data}, {3'b111, 8'hD2});
        drain();
        chk("ack_done", 32'(done_cnt - d0), 32'd1);
        chk("ack_busy", 32'(busy_cyc - b0), 32'd1);

        // DATA0 zero-length
        d0 = done_cnt;
        push_pkt(4'b0011, p_none);
        req(4'b0011, 1'b1);
        drain();
        chk("zlp_done", 32'(done_cnt - d0), 32'd1);

        // DATA1 with 4 bytes, full rate
        push_pkt(4'b1011, p4);
        req(4'b1011, 1'b0);
        send_payload(p4, 1'b1, 1'b0, 1'b0);
        drain();

        // Same packet with backpressure, input gaps, and a stray request mid-packet
        e0 = err_cnt; d0 = done_cnt;
        ready_toggle = 1'b1;
        push_pkt(4'b1011, p4);
        req(4'b1011, 1'b0);
        send_payload(p4, 1'b1, 1'b1, 1'b1);
        drain();
        ready_toggle = 1'b0;
        tick();
        chk("busy_req_no_err", 32'(err_cnt - e0), 32'd0);
        chk("stall_done", 32'(done_cnt - d0), 32'd1);

        // Illegal PID
        e0 = err_cnt;
        req(4'b1001, 1'b0);
        @(negedge clk);
        chk("illegal_err", 32'(tx_pid_err), 32'd1);
        chk("illegal_quiet", {tx_valid, tx_busy}, 32'd0);
        tick();
        tick();
        chk("illegal_err_once", 32'(err_cnt - e0), 32'd1);

        // Payload reaches MAX_PAYLOAD without eop
        push_pkt(4'b0011, p8);
        req(4'b0011, 1'b0);
        send_payload(p8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("max_stops_accept", 32'(tx_lt_ready), 32'd0);
        drain();

        // Async reset mid-packet, then NAK
        sb_en = 1'b0;
        req(4'b1011, 1'b0);
        send_payload(p2, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", {tx_valid, tx_busy, tx_lt_ready}, 32'd0);
        tick();
        rst = 1'b0;
        sbq.delete();
        tick();
        sb_en = 1'b1;
        d0 = done_cnt;
        push_pkt(4'b1010, p_none);
        req(4'b1010, 1'b0);
        @(negedge clk);
        chk("nak_after_rst", {tx_valid, tx_sop, tx_eop, tx_data}, {3'b111, 8'h5A});
        drain();
        chk("nak_done", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/usb_link_tx.md
Name: usb_link_tx

Overview:
Device-side USB link-layer transmitter, the outbound counterpart of the link receiver. On a request from the transfer layer it serialises a handshake packet (PID only) or a data packet (PID, payload, CRC16) into the byte-wide TX FIFO stream with valid/ready, sop and eop framing. It computes the USB CRC16 over the payload on the fly and appends it. It reports busy and done status to link_control.

Parameters:
CRC16_INIT, 16'hFFFF, CRC16 register seed at the start of each data packet.
MAX_PAYLOAD, 1023, maximum payload bytes; reaching it forces the end of the payload.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
tx_pid_en  input  1  one-cycle start request from the transfer layer; honoured only in IDLE
tx_pid  input  4  PID nibble sampled with tx_pid_en
tx_zlp  input  1  sampled with tx_pid_en; 1 = zero-length data packet
tx_lt_valid  input  1  payload byte valid from the transfer layer
tx_lt_data  input  8  payload byte
tx_lt_eop  input  1  marks the last payload byte
tx_lt_ready  output  1  payload byte accepted when high together with tx_lt_valid
tx_valid  output  1  byte valid to the FIFO
tx_data  output  8  byte to the FIFO
tx_sop  output  1  first byte of the packet, qualified by tx_valid
tx_eop  output  1  last byte of the packet, qualified by tx_valid
tx_ready  input  1  FIFO accepts the byte when high together with tx_valid
tx_busy  output  1  high whenever the FSM is not in IDLE
tx_done  output  1  one-cycle pulse after the eop byte is accepted
tx_pid_err  output  1  one-cycle pulse when a request carries an illegal PID

Behaviour:
- Reset values: all outputs 0 (tx_data 8'h00); FSM in IDLE; CRC register set to CRC16_INIT; byte counter 0.
- FSM states and transitions:
  - IDLE -> PID on tx_pid_en with a legal PID.
  - PID -> DATA (data PID, tx_zlp=0) / CRC_LO (data PID, tx_zlp=1) / IDLE (handshake PID).
  - DATA -> CRC_LO once the eop payload byte is accepted.
  - CRC_LO -> CRC_HI -> IDLE.
- Legal PIDs:
  - Handshake: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - Data: DATA0 4'b0011, DATA1 4'b1011.
  - Any other PID: pulse tx_pid_err, stay in IDLE, emit nothing.
- PID byte is {~pid, pid}: ACK=8'hD2, NAK=8'h5A, STALL=8'h1E, DATA0=8'hC3, DATA1=8'h4B. It is sent with tx_sop=1; tx_eop=1 only for handshakes.
- Output stage is a single register. tx_valid/tx_data/tx_sop/tx_eop are held stable until the tx_ready&tx_valid transfer. A new byte may load in the same cycle as a transfer, giving back-to-back bytes at full rate when tx_ready stays 1.
- PID byte appears on tx_valid one cycle after tx_pid_en (latency 1).
- tx_lt_ready = (state==DATA) & (~tx_valid | tx_ready). Each accepted payload byte is registered to tx_data on the next cycle with sop=0 and eop=0.
- CRC16:
  - Polynomial x^16+x^15+x^2+1 (0x8005), reflected.
  - Data processed LSB-first, one byte per cycle, on each accepted payload byte.
  - Register seeded with CRC16_INIT on entry to PID.
  - Transmitted value is the bitwise complement of the register: CRC_LO carries bits [7:0], CRC_HI carries bits [15:8] with tx_eop=1.
  - A receiver running CRC over payload+CRC must see residual 16'h800D.
- Payload counter:
  - Counts accepted payload bytes.
  - When the count reaches MAX_PAYLOAD, the byte is treated as last even without tx_lt_eop.
  - tx_lt_eop is ignored outside DATA.
- tx_done pulses one cycle after the CRC_HI byte (data) or the PID byte (handshake) transfers.
- tx_pid_en while busy is ignored: no error pulse, no effect on the packet in flight.
- Async rst mid-packet: all state clears immediately, tx_valid drops, no eop is generated; the FIFO side must discard the partial packet.
- tx_lt_valid low in DATA: insert idle cycles (tx_valid=0 once the output register drains); the CRC is unaffected.

Test Plan:
- ACK request, tx_ready=1 -> one byte 8'hD2 with sop=1 and eop=1 one cycle after tx_pid_en; tx_done next cycle; tx_busy high for 1 cycle.
- DATA0 with tx_zlp=1 -> bytes C3 (sop), 00, 00 (eop); residual check gives 16'h800D.
- DATA1 with payload 00 01 02 03, tx_ready=1 -> 4B, 00, 01, 02, 03, crc_lo, crc_hi(eop). Six cycles back-to-back after the PID byte. CRC matches the reference-model CRC16 per byte order.
- Same packet with tx_ready toggling 1-0-1-0 and tx_lt_valid gaps -> identical byte sequence, no duplicated or dropped bytes, data held stable while tx_ready=0.
- Illegal PID 4'b1001 (IN) -> tx_pid_err pulse, tx_valid stays 0, tx_busy stays 0; a second tx_pid_en issued mid-packet is ignored.
- rst asserted during DATA after 2 payload bytes -> tx_valid=0 and state IDLE immediately; the next NAK request yields a single 8'h5A with sop and eop.
